// File: rtl/periph_pkg.sv
// Shared peripheral definitions: ALU op encodings, scheduler FSM states and datapath width.
package periph_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_XOR = 2'b10,
    OP_AND = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker: grants the first set request bit
// at or above ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  // Scan NREQ positions starting at ptr; the first pending request wins.
  always_comb begin
    // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    sum        = '0;
    idx        = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = idx;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one external combinational alu8 among NREQ requesters. Round-robin grant,
// registered ALU operands, one tagged result per operation on a valid/ready channel.
module alu_rr_scheduler
  import periph_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ALU_W-1:0] req_a,
  input  logic [NREQ*ALU_W-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_op,
  output logic [ALU_W-1:0]      alu_a,
  output logic [ALU_W-1:0]      alu_b,
  output logic [1:0]            alu_op,
  input  logic [ALU_W-1:0]      alu_y,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [ALU_W-1:0]      rsp_data,
  output logic                  busy,
  output logic [15:0]           op_count
);

  state_e           state_q;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ALU_W-1:0] alu_a_q, alu_b_q, rsp_data_q;
  logic [1:0]       alu_op_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [15:0]      op_count_q;

  logic [NREQ-1:0]  gnt_onehot;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req        (req_valid),
    .ptr        (rr_ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  // Pointer moves to the requester just after the winner, wrapping at NREQ.
  always_comb begin
    rr_ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
  end

  // Grants are only offered while idle.
  assign req_ready = (state_q == IDLE) ? gnt_onehot : '0;

  // Scheduler FSM with its operand, response and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments; all registers here are flops, so each gets a reset value.
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            alu_a_q  <= req_a[gnt_idx*ALU_W +: ALU_W];
            alu_b_q  <= req_b[gnt_idx*ALU_W +: ALU_W];
            alu_op_q <= req_op[gnt_idx*2 +: 2];
            rsp_id_q <= gnt_idx;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= alu_y;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 16'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a behavioural alu8 in the loop.
module tb_alu_rr_scheduler;
  import periph_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a, req_b;
  logic [NREQ*2-1:0] req_op;
  logic [7:0]        alu_a, alu_b, alu_y;
  logic [1:0]        alu_op;
  logic              rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_data;
  logic [15:0]       op_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural alu8.
  always_comb begin
    case (alu_op)
      2'b00:   alu_y = alu_a + alu_b;
      2'b01:   alu_y = alu_a - alu_b;
      2'b10:   alu_y = alu_a ^ alu_b;
      default: alu_y = alu_a & alu_b;
    endcase
  end

  alu_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_y     (alu_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .op_count  (op_count)
  );

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
    req_op[2*i +: 2] = op;
  endtask

  // Called just after a negedge with requests driven. Waits (bounded) for a grant,
  // then samples the EXEC cycle and the first RESP cycle. Returns at RESP negedge+1.
  task automatic serve_one(input bit clear_on_grant, output logic [3:0] g, output logic exec_rv,
                           output logic exec_busy, output logic rv, output logic [1:0] id,
                           output logic [7:0] data);
    bit hit;
    g = '0; exec_rv = 1'bx; exec_busy = 1'bx; rv = 1'bx; id = 'x; data = 'x;
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (req_ready != '0) begin
        g   = req_ready;
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!hit) return;
    @(negedge clk);
    if (clear_on_grant) req_valid = req_valid & ~g;
    #1;
    exec_rv   = rsp_valid;
    exec_busy = busy;
    @(negedge clk);
    #1;
    rv   = rsp_valid;
    id   = rsp_id;
    data = rsp_data;
  endtask

  task automatic test_reset();
    logic [3:0] g; logic erv, eb, rv; logic [1:0] id; logic [7:0] d;
    #3;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_valid_busy: got %b%b want 00", rsp_valid, busy); end
    total++; if ({alu_a, alu_b, alu_op} !== 18'h0) begin bad++; $display("FAIL reset_alu: got %h want 0", {alu_a, alu_b, alu_op}); end
    total++; if ({rsp_id, rsp_data, op_count} !== 26'h0) begin bad++; $display("FAIL reset_rsp: got %h want 0", {rsp_id, rsp_data, op_count}); end
    @(negedge clk);
    rst_n = 1'b1;
    // Bring an operation into RESP, then reset underneath it.
    rsp_ready = 1'b0;
    set_req(3, 8'h11, 8'h22, OP_ADD);
    req_valid = 4'b1000;
    serve_one(1'b1, g, erv, eb, rv, id, d);
    total++; if (g !== 4'b1000) begin bad++; $display("FAIL reset_pre_grant: got %b want 1000", g); end
    total++; if (rv !== 1'b1 || d !== 8'h33) begin bad++; $display("FAIL reset_pre_rsp: got v=%b d=%h want v=1 d=33", rv, d); end
    #1 rst_n = 1'b0;
    #1;
    total++; if ({rsp_valid, busy, rsp_id, rsp_data} !== 12'h0) begin bad++; $display("FAIL reset_mid_rsp: got %h want 0", {rsp_valid, busy, rsp_id, rsp_data}); end
    total++; if ({alu_a, alu_b, alu_op, op_count} !== 34'h0) begin bad++; $display("FAIL reset_mid_alu: got %h want 0", {alu_a, alu_b, alu_op, op_count}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      total++; if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL reset_idle_%0d: got rdy=%b v=%b busy=%b want 0000 0 0", k, req_ready, rsp_valid, busy);
      end
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] g; logic erv, eb, rv; logic [1:0] id; logic [7:0] d;
    @(negedge clk);
    set_req(0, 8'h10, 8'h05, OP_ADD);
    req_valid = 4'b0001;
    serve_one(1'b1, g, erv, eb, rv, id, d);
    total++; if (g !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", g); end
    total++; if (erv !== 1'b0 || eb !== 1'b1) begin bad++; $display("FAIL single_exec: got v=%b busy=%b want 0 1", erv, eb); end
    total++; if (rv !== 1'b1 || id !== 2'd0 || d !== 8'h15) begin bad++; $display("FAIL single_rsp: got v=%b id=%0d d=%h want 1 0 15", rv, id, d); end
    total++; if ({alu_a, alu_b, alu_op} !== {8'h10, 8'h05, 2'b00}) begin bad++; $display("FAIL single_alu: got %h %h %b want 10 05 00", alu_a, alu_b, alu_op); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b0 || op_count !== 16'd1 || busy !== 1'b0) begin bad++; $display("FAIL single_done: got v=%b cnt=%0d busy=%b want 0 1 0", rsp_valid, op_count, busy); end
  endtask

  task automatic test_wrap_arith();
    logic [3:0] g; logic erv, eb, rv; logic [1:0] id; logic [7:0] d;
    @(negedge clk);
    set_req(2, 8'h03, 8'h05, OP_SUB);
    req_valid = 4'b0100;
    serve_one(1'b1, g, erv, eb, rv, id, d);
    total++; if (g !== 4'b0100 || id !== 2'd2 || d !== 8'hFE) begin bad++; $display("FAIL wrap_sub: got g=%b id=%0d d=%h want 0100 2 fe", g, id, d); end
    @(negedge clk);
    set_req(2, 8'hFF, 8'h01, OP_ADD);
    req_valid = 4'b0100;
    serve_one(1'b1, g, erv, eb, rv, id, d);
    total++; if (g !== 4'b0100 || id !== 2'd2 || d !== 8'h00) begin bad++; $display("FAIL wrap_add: got g=%b id=%0d d=%h want 0100 2 00", g, id, d); end
    @(negedge clk); #1;
    total++; if (op_count !== 16'd3) begin bad++; $display("FAIL wrap_count: got %0d want 3", op_count); end
  endtask

  task automatic test_round_robin();
    logic [3:0] g; logic erv, eb, rv; logic [1:0] id; logic [7:0] d;
    logic [3:0] exp_g [6];
    logic [7:0] exp_d [6];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    exp_d = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h01, 8'h11};
    // rr_ptr is 3 here; one op from requester 3 brings it back to 0.
    @(negedge clk);
    set_req(3, 8'h00, 8'h01, OP_SUB);
    req_valid = 4'b1000;
    serve_one(1'b1, g, erv, eb, rv, id, d);
    total++; if (g !== 4'b1000 || d !== 8'hFF) begin bad++; $display("FAIL rr_align: got g=%b d=%h want 1000 ff", g, d); end
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(16 * i), 8'h01, OP_ADD);
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      serve_one(1'b0, g, erv, eb, rv, id, d);
      total++; if (g !== exp_g[k] || d !== exp_d[k]) begin bad++; $display("FAIL rr_all_%0d: got g=%b d=%h want %b %h", k, g, d, exp_g[k], exp_d[k]); end
    end
    // rr_ptr is now 2 with only requesters 1 and 3 pending.
    @(negedge clk);
    set_req(1, 8'hF0, 8'h3C, OP_AND);
    set_req(3, 8'h0F, 8'h3C, OP_XOR);
    req_valid = 4'b1010;
    serve_one(1'b0, g, erv, eb, rv, id, d);
    total++; if (g !== 4'b1000 || id !== 2'd3 || d !== 8'h33) begin bad++; $display("FAIL rr_pair_first: got g=%b id=%0d d=%h want 1000 3 33", g, id, d); end
    @(negedge clk);
    serve_one(1'b0, g, erv, eb, rv, id, d);
    req_valid = 4'b0000;
    total++; if (g !== 4'b0010 || id !== 2'd1 || d !== 8'h30) begin bad++; $display("FAIL rr_pair_second: got g=%b id=%0d d=%h want 0010 1 30", g, id, d); end
    @(negedge clk); #1;
    total++; if (op_count !== 16'd12) begin bad++; $display("FAIL rr_count: got %0d want 12", op_count); end
  endtask

  task automatic test_backpressure();
    logic [3:0] g; logic erv, eb, rv; logic [1:0] id; logic [7:0] d;
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(0, 8'h40, 8'h02, OP_XOR);
    req_valid = 4'b0001;
    serve_one(1'b1, g, erv, eb, rv, id, d);
    total++; if (g !== 4'b0001 || d !== 8'h42) begin bad++; $display("FAIL bp_grant: got g=%b d=%h want 0001 42", g, d); end
    set_req(1, 8'h07, 8'h03, OP_SUB);
    req_valid = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      total++; if ({rsp_valid, rsp_id, rsp_data, req_ready, busy} !== {1'b1, 2'd0, 8'h42, 4'b0000, 1'b1}) begin
        bad++; $display("FAIL bp_hold_%0d: got v=%b id=%0d d=%h rdy=%b busy=%b want 1 0 42 0000 1", k, rsp_valid, rsp_id, rsp_data, req_ready, busy);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b0 || op_count !== 16'd13 || req_ready !== 4'b0010) begin
      bad++; $display("FAIL bp_release: got v=%b cnt=%0d rdy=%b want 0 13 0010", rsp_valid, op_count, req_ready);
    end
    serve_one(1'b1, g, erv, eb, rv, id, d);
    total++; if (g !== 4'b0010 || id !== 2'd1 || d !== 8'h04) begin bad++; $display("FAIL bp_next: got g=%b id=%0d d=%h want 0010 1 04", g, id, d); end
    @(negedge clk); #1;
    total++; if (op_count !== 16'd14) begin bad++; $display("FAIL bp_count: got %0d want 14", op_count); end
  endtask

  task automatic test_counter_wrap();
    logic [3:0] g; logic erv, eb, rv; logic [1:0] id; logic [7:0] d;
    @(negedge clk);
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    #1;
    total++; if (op_count !== 16'hFFFF) begin bad++; $display("FAIL cnt_preload: got %h want ffff", op_count); end
    @(negedge clk);
    set_req(2, 8'hAA, 8'h0F, OP_AND);
    req_valid = 4'b0100;
    serve_one(1'b1, g, erv, eb, rv, id, d);
    total++; if (g !== 4'b0100 || d !== 8'h0A) begin bad++; $display("FAIL cnt_op: got g=%b d=%h want 0100 0a", g, d); end
    @(negedge clk); #1;
    total++; if (op_count !== 16'h0000) begin bad++; $display("FAIL cnt_wrap: got %h want 0000", op_count); end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_wrap_arith();
    test_round_robin();
    test_backpressure();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
